// File: rtl/io_led_btn_core.sv
// io_led_btn_core
//   LED PWM driver and debounced push-button block for a register slave.
//
//   Build option: define IO_CORE_IRQ_EN to generate the button interrupt;
//   when undefined irq is tied to 0 and reg_irq_mask is ignored.
//
//   Ports:
//     S_AXI_ACLK     in   clock, all logic on the rising edge
//     S_AXI_ARESETN  in   synchronous active-low reset
//     reg_led_ctrl   in   [NUM_LEDS-1:0] LED enables, [8] PWM bypass (full on)
//     reg_pwm_duty   in   [PWM_BITS-1:0] PWM duty
//     reg_irq_mask   in   [NUM_BTNS-1:0] interrupt mask
//     btn_clr_stb    in   one-cycle strobe, write to the clear register
//     btn_clr_data   in   [NUM_BTNS-1:0] write-1-to-clear sticky mask
//     btn_in         in   raw asynchronous buttons, active-high
//     led_out        out  registered LED drive, active-high
//     btn_status     out  [7:0] debounced levels, [15:8] sticky rise flags
//     irq            out  registered level interrupt
module io_led_btn_core #(
    parameter int NUM_LEDS        = 4,
    parameter int NUM_BTNS        = 4,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int PWM_BITS        = 8
) (
    input  logic                S_AXI_ACLK,
    input  logic                S_AXI_ARESETN,
    input  logic [31:0]         reg_led_ctrl,
    input  logic [31:0]         reg_pwm_duty,
    input  logic [31:0]         reg_irq_mask,
    input  logic                btn_clr_stb,
    input  logic [31:0]         btn_clr_data,
    input  logic [NUM_BTNS-1:0] btn_in,
    output logic [NUM_LEDS-1:0] led_out,
    output logic [31:0]         btn_status,
    output logic                irq
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTNS-1:0] sync1;
    logic [NUM_BTNS-1:0] sync2;
    logic [NUM_BTNS-1:0] deb;
    logic [NUM_BTNS-1:0] sticky;
    logic [NUM_BTNS-1:0] rise;
    logic [NUM_BTNS-1:0] clr_mask;
    logic [CW-1:0]       db_cnt [NUM_BTNS];
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_on;

    // Only slices of the register words are consumed.
    logic unused_inputs;
    assign unused_inputs = ^{reg_led_ctrl, reg_pwm_duty, reg_irq_mask, btn_clr_data};

    // A rise is the edge on which the debounced level flips from 0 to 1.
    always_comb begin
        rise = '0;
        for (int unsigned i = 0; i < NUM_BTNS; i++) begin
            rise[i] = sync2[i] & ~deb[i] & (db_cnt[i] == CNT_MAX);
        end
        clr_mask = btn_clr_stb ? btn_clr_data[NUM_BTNS-1:0] : '0;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            sync1  <= '0;
            sync2  <= '0;
            deb    <= '0;
            sticky <= '0;
            for (int unsigned i = 0; i < NUM_BTNS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            for (int unsigned i = 0; i < NUM_BTNS; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_MAX) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
            // Set wins over a coincident clear.
            sticky <= (sticky & ~clr_mask) | rise;
        end
    end

    assign pwm_on = reg_led_ctrl[8] | (pwm_cnt < reg_pwm_duty[PWM_BITS-1:0]);

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            pwm_cnt <= '0;
            led_out <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            led_out <= reg_led_ctrl[NUM_LEDS-1:0] & {NUM_LEDS{pwm_on}};
        end
    end

    always_comb begin
        btn_status                       = '0;
        btn_status[NUM_BTNS-1:0]         = deb;
        btn_status[8 +: NUM_BTNS]        = sticky;
    end

`ifdef IO_CORE_IRQ_EN
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            irq <= 1'b0;
        end else begin
            irq <= |(sticky & reg_irq_mask[NUM_BTNS-1:0]);
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule
